// File: rtl/if_id_hazard.sv
// if_id_hazard: IF/ID pipeline register with load-use stall and flush control.
// Optional HAZARD_STALL_COUNT_EN adds a saturating stall_count output.
module if_id_hazard (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] pc_in,
   input  logic [31:0] instr_in,
   input  logic        instr_valid,
   input  logic        flush,
   input  logic        idex_memread,
   input  logic [4:0]  idex_rd,
   output logic [63:0] pc_out,
   output logic [31:0] instr_out,
   output logic        valid_out,
   output logic        pc_write,
   output logic        ctrl_bubble
`ifdef HAZARD_STALL_COUNT_EN
   ,
   output logic [31:0] stall_count
`endif
);
   localparam logic [31:0] NOP = 32'h00000013;
   typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;
   state_t state, state_nxt;
   logic hazard, stall;
   assign hazard = valid_out & idex_memread & (idex_rd != 5'd0) &
                   ((idex_rd == instr_out[19:15]) | (idex_rd == instr_out[24:20]));
   // flush wins over hazard; hazard is only acted on from RUN
   always_comb begin
      state_nxt   = RUN;
      pc_write    = 1'b1;
      ctrl_bubble = 1'b0;
      stall       = 1'b0;
      if (flush) begin
         state_nxt   = FLUSH;
         ctrl_bubble = 1'b1;
      end else if (state == RUN && hazard) begin
         state_nxt   = STALL;
         pc_write    = 1'b0;
         ctrl_bubble = 1'b1;
         stall       = 1'b1;
      end else if (state == FLUSH) begin
         ctrl_bubble = 1'b1;
      end
      if (!rst_n) begin
         pc_write    = 1'b1;
         ctrl_bubble = 1'b1;
      end
   end
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         pc_out    <= 64'd0;
         instr_out <= NOP;
         valid_out <= 1'b0;
      end else begin
         state <= state_nxt;
         if (flush) begin
            instr_out <= NOP;
            valid_out <= 1'b0;
         end else if (!stall) begin
            pc_out    <= pc_in;
            instr_out <= instr_valid ? instr_in : NOP;
            valid_out <= instr_valid;
         end
      end
   end
`ifdef HAZARD_STALL_COUNT_EN
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_count <= 32'd0;
      else if (stall && stall_count != 32'hFFFFFFFF)
         stall_count <= stall_count + 32'd1;
   end
`endif
endmodule

// File: tb/tb_if_id_hazard.sv
// tb_if_id_hazard: directed bench with a behavioural IF/ID model checked every cycle.
module tb_if_id_hazard;
   localparam logic [31:0] NOP = 32'h00000013;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] pc_in;
   logic [31:0] instr_in;
   logic        instr_valid, flush, idex_memread;
   logic [4:0]  idex_rd;
   logic [63:0] pc_out;
   logic [31:0] instr_out;
   logic        valid_out, pc_write, ctrl_bubble;
`ifdef HAZARD_STALL_COUNT_EN
   logic [31:0] stall_count;
`endif
   int vectors = 0;
   int errors  = 0;

   if_id_hazard dut (
      .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .instr_in(instr_in),
      .instr_valid(instr_valid), .flush(flush), .idex_memread(idex_memread),
      .idex_rd(idex_rd), .pc_out(pc_out), .instr_out(instr_out),
      .valid_out(valid_out), .pc_write(pc_write), .ctrl_bubble(ctrl_bubble)
`ifdef HAZARD_STALL_COUNT_EN
      , .stall_count(stall_count)
`endif
   );

   always #5 clk = ~clk;

   // Model: what the register holds, and what happened on the previous edge.
   logic [63:0] m_pc = 64'd0;
   logic [31:0] m_instr = NOP;
   bit          m_valid = 1'b0;
   bit          m_was_stall = 1'b0;
   bit          m_was_flush = 1'b0;
   longint      m_stalls = 0;
   longint      cnt_base = 0;

   function automatic bit m_hazard();
      logic [4:0] rs1, rs2;
      rs1 = m_instr[19:15];
      rs2 = m_instr[24:20];
      return m_valid && idex_memread && idex_rd != 0 && (idex_rd == rs1 || idex_rd == rs2);
   endfunction

   function automatic bit m_stalls_now();
      return !flush && !m_was_stall && !m_was_flush && m_hazard();
   endfunction

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc <= 0; m_instr <= NOP; m_valid <= 0;
         m_was_stall <= 0; m_was_flush <= 0; m_stalls <= 0;
      end else if (flush) begin
         m_instr <= NOP; m_valid <= 0; m_was_stall <= 0; m_was_flush <= 1;
      end else if (m_stalls_now()) begin
         m_was_stall <= 1; m_was_flush <= 0; m_stalls <= m_stalls + 1;
      end else begin
         m_pc <= pc_in; m_instr <= instr_valid ? instr_in : NOP; m_valid <= instr_valid;
         m_was_stall <= 0; m_was_flush <= 0;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      bit exp_pw, exp_bub;
      exp_pw  = !rst_n || !m_stalls_now();
      exp_bub = !rst_n || flush || m_was_flush || m_stalls_now();
      chk("m_pc_out", pc_out, m_pc);
      chk("m_instr_out", {32'd0, instr_out}, {32'd0, m_instr});
      chk("m_valid_out", {63'd0, valid_out}, {63'd0, m_valid});
      chk("m_pc_write", {63'd0, pc_write}, {63'd0, exp_pw});
      chk("m_ctrl_bubble", {63'd0, ctrl_bubble}, {63'd0, exp_bub});
`ifdef HAZARD_STALL_COUNT_EN
      chk("m_stall_count", {32'd0, stall_count},
          (cnt_base + m_stalls > 64'hFFFFFFFF) ? 64'hFFFFFFFF : cnt_base + m_stalls);
`endif
   end

   task automatic setin(input logic [63:0] p, input logic [31:0] i, input logic iv,
                        input logic fl, input logic mr, input logic [4:0] rd);
      pc_in = p; instr_in = i; instr_valid = iv; flush = fl; idex_memread = mr; idex_rd = rd;
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   logic [63:0] tbl_pc [8] = '{64'h300, 64'h304, 64'h308, 64'h30C, 64'h310, 64'h314, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
   logic [31:0] tbl_in [8] = '{32'h00A00093, 32'h00208133, 32'hFFFFFFFF, 32'h0, 32'h12345678, 32'h00B50533, 32'hDEADBEEF, 32'h00100073};
   logic        tbl_v  [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

   initial begin
      rst_n = 1'b1;
      setin(64'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      chk("rst_pc", pc_out, 64'h0);
      chk("rst_instr", {32'd0, instr_out}, {32'd0, NOP});
      chk("rst_valid", {63'd0, valid_out}, 64'd0);
      // flow
      setin(64'h100, 32'h00A00093, 1'b1, 1'b0, 1'b0, 5'd0); tick();
      chk("flow_pc", pc_out, 64'h100);
      chk("flow_instr", {32'd0, instr_out}, 64'h00A00093);
      chk("flow_valid", {63'd0, valid_out}, 64'd1);
      // load-use on rs2
      setin(64'h104, 32'h00208133, 1'b1, 1'b0, 1'b0, 5'd0); tick();
      setin(64'h108, 32'h00300193, 1'b1, 1'b0, 1'b1, 5'd2); #1;
      chk("lu_pc_write", {63'd0, pc_write}, 64'd0);
      chk("lu_bubble", {63'd0, ctrl_bubble}, 64'd1);
      tick();
      chk("lu_hold_instr", {32'd0, instr_out}, 64'h00208133);
      chk("lu_hold_pc", pc_out, 64'h104);
      chk("lu_stall_pw", {63'd0, pc_write}, 64'd1);
      chk("lu_stall_bub", {63'd0, ctrl_bubble}, 64'd0);
      tick();
      chk("lu_resume_pc", pc_out, 64'h108);
      chk("lu_resume_instr", {32'd0, instr_out}, 64'h00300193);
`ifdef HAZARD_STALL_COUNT_EN
      chk("lu_count", {32'd0, stall_count}, 64'd1);
`endif
      // no false stall
      setin(64'h10C, 32'h00208133, 1'b1, 1'b0, 1'b0, 5'd0); tick();
      setin(64'h110, 32'h00A00093, 1'b1, 1'b0, 1'b1, 5'd0); #1;
      chk("nf_rd0_pw", {63'd0, pc_write}, 64'd1);
      chk("nf_rd0_bub", {63'd0, ctrl_bubble}, 64'd0);
      setin(64'h110, 32'h00A00093, 1'b1, 1'b0, 1'b0, 5'd2); #1;
      chk("nf_mr0_pw", {63'd0, pc_write}, 64'd1);
      chk("nf_mr0_bub", {63'd0, ctrl_bubble}, 64'd0);
      // flush beats hazard
      setin(64'h110, 32'h00A00093, 1'b1, 1'b1, 1'b1, 5'd2); #1;
      chk("fh_pw", {63'd0, pc_write}, 64'd1);
      chk("fh_bub", {63'd0, ctrl_bubble}, 64'd1);
      tick();
      chk("fh_instr", {32'd0, instr_out}, {32'd0, NOP});
      chk("fh_valid", {63'd0, valid_out}, 64'd0);
      chk("fh_pc_held", pc_out, 64'h10C);
      setin(64'h114, 32'h00A00093, 1'b1, 1'b0, 1'b0, 5'd0); #1;
      chk("fh_flush_state_bub", {63'd0, ctrl_bubble}, 64'd1);
`ifdef HAZARD_STALL_COUNT_EN
      chk("fh_count", {32'd0, stall_count}, 64'd1);
`endif
      tick();
      // rs1 hazard, back-to-back occurrences, flush during STALL
      setin(64'h118, 32'h00208133, 1'b1, 1'b0, 1'b0, 5'd0); tick();
      setin(64'h11C, 32'h00A00093, 1'b1, 1'b0, 1'b1, 5'd1); #1;
      chk("rs1_pw", {63'd0, pc_write}, 64'd0);
      tick();
      setin(64'h120, 32'h00208133, 1'b1, 1'b0, 1'b1, 5'd1); tick();
      chk("b2b_pc", pc_out, 64'h120);
      chk("b2b_pw", {63'd0, pc_write}, 64'd0);
      tick();
      setin(64'h124, 32'h00A00093, 1'b1, 1'b1, 1'b1, 5'd1); #1;
      chk("sf_bub", {63'd0, ctrl_bubble}, 64'd1);
      tick();
      chk("sf_pc", pc_out, 64'h120);
      chk("sf_instr", {32'd0, instr_out}, {32'd0, NOP});
`ifdef HAZARD_STALL_COUNT_EN
      chk("b2b_count", {32'd0, stall_count}, 64'd3);
`endif
      // asynchronous reset mid-cycle
      setin(64'h200, 32'h00A00093, 1'b1, 1'b0, 1'b0, 5'd0); tick();
      #2 rst_n = 1'b0;
      #1;
      chk("ar_pc", pc_out, 64'h0);
      chk("ar_instr", {32'd0, instr_out}, {32'd0, NOP});
      chk("ar_valid", {63'd0, valid_out}, 64'd0);
      chk("ar_pw", {63'd0, pc_write}, 64'd1);
      chk("ar_bub", {63'd0, ctrl_bubble}, 64'd1);
      tick(); rst_n = 1'b1;
      // reset aborts STALL
      setin(64'h204, 32'h00208133, 1'b1, 1'b0, 1'b0, 5'd0); tick();
      setin(64'h208, 32'h00A00093, 1'b1, 1'b0, 1'b1, 5'd2); tick();
      rst_n = 1'b0; #1; tick(); rst_n = 1'b1;
      setin(64'h20C, 32'h00A00093, 1'b1, 1'b0, 0, 5'd0); #1;
      chk("rs_stall_bub", {63'd0, ctrl_bubble}, 64'd0);
      tick();
      // reset aborts FLUSH
      setin(64'h210, 32'h00A00093, 1'b1, 1'b1, 1'b0, 5'd0); tick();
      setin(64'h214, 32'h00A00093, 1'b1, 1'b0, 1'b0, 5'd0);
      rst_n = 1'b0; #1; tick(); rst_n = 1'b1; #1;
      chk("rs_flush_bub", {63'd0, ctrl_bubble}, 64'd0);
      tick();
      chk("rs_flush_load", pc_out, 64'h214);
      // plain flow table
      for (int i = 0; i < 8; i++) begin
         setin(tbl_pc[i], tbl_in[i], tbl_v[i], 1'b0, 1'b1, 5'd2);
         tick();
      end
`ifdef HAZARD_STALL_COUNT_EN
      setin(64'h400, 32'h00208133, 1'b1, 1'b0, 1'b0, 5'd0); tick();
      force dut.stall_count = 32'hFFFFFFFE;
      cnt_base = 64'hFFFFFFFE - m_stalls;
      #1 release dut.stall_count;
      setin(64'h404, 32'h00208133, 1'b1, 1'b0, 1'b1, 5'd2);
      repeat (4) tick();
      chk("sat_count", {32'd0, stall_count}, 64'hFFFFFFFF);
`endif
      setin(64'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
      repeat (2) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/if_id_hazard.md
IF_ID_HAZARD -- requirements
Module: if_id_hazard

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its falling edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port pc_in, input, 64, fetch-stage PC.
REQ-004 SHALL have port instr_in, input, 32, fetched instruction.
REQ-005 SHALL have port instr_valid, input, 1, instr_in/pc_in valid this cycle.
REQ-006 SHALL have port flush, input, 1, taken branch resolved downstream; squash IF/ID.
REQ-007 SHALL have port idex_memread, input, 1, memread currently held in ID/EX.
REQ-008 SHALL have port idex_rd, input, 5, destination register currently held in ID/EX.
REQ-009 SHALL have port pc_out, output, 64, registered PC to decode.
REQ-010 SHALL have port instr_out, output, 32, registered instruction to decode.
REQ-011 SHALL have port valid_out, output, 1, instr_out holds a live instruction.
REQ-012 SHALL have port pc_write, output, 1, 0 = fetch must hold PC.
REQ-013 SHALL have port ctrl_bubble, output, 1, 1 = decode drives all ID/EX control inputs to 0.

Function
REQ-014 SHALL define hazard = valid_out & idex_memread & (idex_rd != 0) & (idex_rd == instr_out[19:15] | idex_rd == instr_out[24:20]), combinational.
REQ-015 SHALL implement FSM states RUN, STALL, FLUSH; reset state RUN.
REQ-016 RUN: on hazard & !flush SHALL go to STALL; on flush SHALL go to FLUSH; else stay RUN.
REQ-017 STALL SHALL last exactly one cycle, then go to RUN (or FLUSH if flush asserted).
REQ-018 FLUSH SHALL last exactly one cycle, then go to RUN unless flush is still asserted.
REQ-019 While hazard is true in RUN: pc_write=0, ctrl_bubble=1, IF/ID registers hold (same cycle, combinational).
REQ-020 In STALL SHALL not re-evaluate hazard; pc_write=1, ctrl_bubble=0, IF/ID loads normally.
REQ-021 flush SHALL override hazard: on a flush edge instr_out<=32'h00000013, valid_out<=0, pc_out held, pc_write=1, ctrl_bubble=1.
REQ-022 In FLUSH, ctrl_bubble SHALL be 1 and IF/ID loads normally.
REQ-023 Normal load: pc_out<=pc_in; instr_out<=instr_valid ? instr_in : 32'h00000013; valid_out<=instr_valid.
REQ-024 Latency SHALL be one clock from pc_in/instr_in to pc_out/instr_out when not stalled.
REQ-025 A hazard with valid_out=0 (bubble) SHALL never stall.
REQ-026 Back-to-back loads feeding one consumer SHALL cause only one stall cycle per hazard occurrence.

Reset
REQ-027 rst_n low SHALL immediately force pc_out=0, instr_out=32'h00000013, valid_out=0, state RUN, stall counter 0.
REQ-028 While rst_n low SHALL drive pc_write=1, ctrl_bubble=1.
REQ-029 Reset asserted mid-STALL or mid-FLUSH SHALL abort it; first post-reset edge behaves as RUN.

Configuration
REQ-030 With macro HAZARD_STALL_COUNT_EN defined SHALL add output stall_count, 32 bits, incremented on each edge entering STALL, saturating at 32'hFFFFFFFF, cleared by reset.
REQ-031 Without HAZARD_STALL_COUNT_EN the port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-032 Reset: rst_n=0 mid-cycle -> instr_out=0x00000013, valid_out=0, pc_out=0 immediately, no clock needed.
REQ-033 Flow: instr_valid=1, pc_in=0x100, instr_in=0x00A00093 -> after one falling edge pc_out=0x100, instr_out=0x00A00093, valid_out=1.
REQ-034 Load-use: instr_out=0x00208133 (rs1=1,rs2=2), idex_memread=1, idex_rd=2 -> pc_write=0, ctrl_bubble=1 for one cycle, instr_out held, then normal; stall_count=1 when enabled.
REQ-035 No false stall: same instr_out with idex_rd=0 or idex_memread=0 -> pc_write=1, ctrl_bubble=0.
REQ-036 Flush vs hazard: hazard true and flush=1 same edge -> instr_out=0x00000013, valid_out=0, state FLUSH, no STALL entry, stall_count unchanged.
REQ-037 Saturation (macro on): preload counter to 0xFFFFFFFF via forced hazards -> further hazard leaves stall_count=0xFFFFFFFF.
